// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order issue scoreboard for an ALU/MUL pipeline.
// Tracks pending destination registers and a writeback-slot shift register
// (slot 1 = writeback this cycle), and stalls on RAW, WAW, writeback-port
// collisions and busy units.
// Optional feature: define HAZARD_WB_FORWARD_EN to let an operand matching the
// current writeback be forwarded instead of stalling.
module hazard_scoreboard #(
  parameter int REG_ADDRESS_SIZE = 5,
  parameter int ALU_LATENCY      = 1,
  parameter int MUL_LATENCY      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic                        issue_use_alu,
  input  logic                        issue_use_mul,
  input  logic                        issue_w,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_dest,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_r1,
  input  logic [REG_ADDRESS_SIZE-1:0] issue_r2,
  input  logic                        issue_r2_used,
  input  logic                        alu_busy,
  input  logic                        mul_busy,
  output logic                        stall,
  output logic                        wb_valid,
  output logic [REG_ADDRESS_SIZE-1:0] wb_dest,
  output logic [3:0]                  inflight,
  output logic                        fwd_r1,
  output logic                        fwd_r2
);

  localparam int NREG = 1 << REG_ADDRESS_SIZE;

  logic [NREG-1:0]                                  r_pend;
  logic [NREG-1:0]                                  w_pend_nxt;
  logic [MUL_LATENCY:1]                             r_vld;
  logic [MUL_LATENCY:1][REG_ADDRESS_SIZE-1:0]       r_dst;
  // One extra always-empty slot above the top so slot k+1 is always addressable.
  logic [MUL_LATENCY+1:1]                           w_vld_pad;
  logic [MUL_LATENCY+1:1][REG_ADDRESS_SIZE-1:0]     w_dst_pad;
  logic [MUL_LATENCY:1]                             w_ld_sel;
  logic [3:0]                                       w_lat;
  logic                                             w_wr;
  logic                                             w_fwd1;
  logic                                             w_fwd2;
  logic                                             w_raw;
  logic                                             w_waw;
  logic                                             w_struct;
  logic                                             w_busy;
  logic                                             w_load;

  assign w_vld_pad = {1'b0, r_vld};
  assign w_dst_pad = {{REG_ADDRESS_SIZE{1'b0}}, r_dst};

  // Result latency of the presented instruction.
  assign w_lat = issue_use_mul ? 4'(MUL_LATENCY) : 4'(ALU_LATENCY);

  // Writes to register 0 are discarded: no slot, no pending bit.
  assign w_wr = issue_w && (issue_dest != '0);

`ifdef HAZARD_WB_FORWARD_EN
  assign w_fwd1 = r_vld[1] && (issue_r1 == r_dst[1]);
  assign w_fwd2 = r_vld[1] && issue_r2_used && (issue_r2 == r_dst[1]);
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  assign fwd_r1 = w_fwd1;
  assign fwd_r2 = w_fwd2;

  // Target slot select and writeback-port collision: slot L+1 shifts into slot L
  // at the same edge the new result would be loaded there.
  always_comb begin
    w_ld_sel = '0;
    w_struct = 1'b0;
    for (int k = 1; k <= MUL_LATENCY; k++) begin
      if (w_lat == 4'(k)) begin
        w_ld_sel[k] = 1'b1;
        w_struct    = w_wr && w_vld_pad[k+1];
      end
    end
  end

  assign w_raw  = (r_pend[issue_r1] && !w_fwd1) ||
                  (issue_r2_used && r_pend[issue_r2] && !w_fwd2);
  // Slot 1's dest is still pending this cycle, so WAW covers it too.
  assign w_waw  = w_wr && r_pend[issue_dest];
  assign w_busy = (issue_use_alu && alu_busy) || (issue_use_mul && mul_busy);
  assign stall  = issue_valid && (w_raw || w_waw || w_struct || w_busy);
  assign w_load = issue_valid && !stall && w_wr;

  // Pending update: retire the writeback dest, then mark the new dest.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_vld[1]) w_pend_nxt[r_dst[1]] = 1'b0;
    if (w_load)   w_pend_nxt[issue_dest] = 1'b1;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  // Writeback slots shift toward slot 1; an accepted write loads slot L.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_dst <= '0;
    end else begin
      for (int k = 1; k <= MUL_LATENCY; k++) begin
        if (w_load && w_ld_sel[k]) begin
          r_vld[k] <= 1'b1;
          r_dst[k] <= issue_dest;
        end else begin
          r_vld[k] <= w_vld_pad[k+1];
          r_dst[k] <= w_dst_pad[k+1];
        end
      end
    end
  end

  assign wb_valid = r_vld[1];
  // Empty slots always carry dest 0, so no masking is needed here.
  assign wb_dest  = r_dst[1];

  // Count of occupied slots.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= MUL_LATENCY; k++) inflight = inflight + 4'(r_vld[k]);
  end

endmodule
